// File: rtl/bram1_arbiter_pkg.sv
// Shared types for the two-port BRAM arbiter: port identifiers and the
// per-cycle tag that travels alongside a BRAM access.
package bram1_arbiter_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e port;
        logic  is_read;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, port: PORT_A, is_read: 1'b0};

    function automatic port_e other_port(input port_e p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/bram1_arbiter_rr.sv
// Two-way round-robin grant with a one-bit priority pointer; grants are
// combinational from the valids so a lone requester wins in the same cycle.
module bram1_arbiter_rr
    import bram1_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic valid_a,
    input  logic valid_b,
    output logic grant_a,
    output logic grant_b
);

    port_e ptr_q;
    port_e ptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PORT_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Grants are forced low while reset is held so nothing handshakes then.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        ptr_d   = ptr_q;
        if (rst_n) begin
            if (valid_a && valid_b) begin
                grant_a = (ptr_q == PORT_A);
                grant_b = (ptr_q == PORT_B);
            end else begin
                grant_a = valid_a;
                grant_b = valid_b;
            end
        end
        if (grant_a) begin
            ptr_d = other_port(PORT_A);
        end else if (grant_b) begin
            ptr_d = other_port(PORT_B);
        end
    end

endmodule

// File: rtl/bram1_arbiter.sv
// Arbitrates two request ports onto one single-port BRAM and routes read
// data back to the issuing port after the BRAM's read latency.
module bram1_arbiter
    import bram1_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1,
    parameter int PIPELINED  = 0
) (
    input  logic                  CLK,
    input  logic                  RST_N,

    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_data,
    output logic                  a_resp_valid,
    output logic [DATA_WIDTH-1:0] a_resp_data,

    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_data,
    output logic                  b_resp_valid,
    output logic [DATA_WIDTH-1:0] b_resp_data,

    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_do
);

    localparam int DEPTH = 1 + PIPELINED;

    logic grant_a;
    logic grant_b;
    tag_t tag_q [DEPTH];
    tag_t tag_d [DEPTH];
    tag_t tag_out;

    bram1_arbiter_rr u_rr (
        .clk     (CLK),
        .rst_n   (RST_N),
        .valid_a (a_req_valid),
        .valid_b (b_req_valid),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;

    // Outside a handshake every BRAM input is parked at zero.
    always_comb begin
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_di   = '0;
        if (grant_a) begin
            bram_en   = 1'b1;
            bram_we   = a_req_we;
            bram_addr = a_req_addr;
            bram_di   = a_req_data;
        end else if (grant_b) begin
            bram_en   = 1'b1;
            bram_we   = b_req_we;
            bram_addr = b_req_addr;
            bram_di   = b_req_data;
        end
    end

    always_comb begin
        tag_d[0].valid   = grant_a | grant_b;
        tag_d[0].port    = grant_b ? PORT_B : PORT_A;
        tag_d[0].is_read = (grant_a & ~a_req_we) | (grant_b & ~b_req_we);
        for (int i = 1; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Clearing the tags on reset is what drops any read still in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= TAG_IDLE;
            end
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag_out      = tag_q[DEPTH-1];
    assign a_resp_valid = tag_out.valid & tag_out.is_read & (tag_out.port == PORT_A);
    assign b_resp_valid = tag_out.valid & tag_out.is_read & (tag_out.port == PORT_B);
    assign a_resp_data  = bram_do;
    assign b_resp_data  = bram_do;

endmodule

// File: tb/tb_bram1_arbiter.sv
// Drives identical traffic into a PIPELINED=0 and a PIPELINED=1 arbiter, each
// with its own BRAM model, and scoreboards grants and read responses.
module tb_bram1_arbiter;

    typedef struct {
        int         due;
        logic       port;
        logic [7:0] data;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       a_req_valid, a_req_we, b_req_valid, b_req_we;
    logic [3:0] a_req_addr, b_req_addr;
    logic [7:0] a_req_data, b_req_data;

    wire  [1:0]      a_ready, b_ready, a_rv, b_rv, bram_en, bram_we;
    wire  [1:0][7:0] a_rd, b_rd, bram_di;
    wire  [1:0][3:0] bram_addr;
    logic [7:0]      do0, do1, rd1a;
    logic [7:0]      mem0 [16];
    logic [7:0]      mem1 [16];

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t sb0 [$];
    exp_t sb1 [$];

    logic       ptr_m;
    logic [7:0] shadow [16];
    logic       exp_ga, exp_gb, exp_we;
    logic [3:0] exp_addr;
    logic [7:0] exp_di;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    bram1_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .PIPELINED(0)) dut0 (
        .CLK(CLK), .RST_N(RST_N),
        .a_req_valid(a_req_valid), .a_req_ready(a_ready[0]), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_data(a_req_data),
        .a_resp_valid(a_rv[0]), .a_resp_data(a_rd[0]),
        .b_req_valid(b_req_valid), .b_req_ready(b_ready[0]), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_data(b_req_data),
        .b_resp_valid(b_rv[0]), .b_resp_data(b_rd[0]),
        .bram_en(bram_en[0]), .bram_we(bram_we[0]), .bram_addr(bram_addr[0]),
        .bram_di(bram_di[0]), .bram_do(do0)
    );

    bram1_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .PIPELINED(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N),
        .a_req_valid(a_req_valid), .a_req_ready(a_ready[1]), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_data(a_req_data),
        .a_resp_valid(a_rv[1]), .a_resp_data(a_rd[1]),
        .b_req_valid(b_req_valid), .b_req_ready(b_ready[1]), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_data(b_req_data),
        .b_resp_valid(b_rv[1]), .b_resp_data(b_rd[1]),
        .bram_en(bram_en[1]), .bram_we(bram_we[1]), .bram_addr(bram_addr[1]),
        .bram_di(bram_di[1]), .bram_do(do1)
    );

    // Write-first single-port BRAMs with one and two cycles of read latency.
    always @(posedge CLK) begin
        if (bram_en[0]) begin
            if (bram_we[0]) mem0[bram_addr[0]] <= bram_di[0];
            do0 <= bram_we[0] ? bram_di[0] : mem0[bram_addr[0]];
        end
    end

    always @(posedge CLK) begin
        if (bram_en[1]) begin
            if (bram_we[1]) mem1[bram_addr[1]] <= bram_di[1];
            rd1a <= bram_we[1] ? bram_di[1] : mem1[bram_addr[1]];
        end
        do1 <= rd1a;
    end

    // Response monitors: outside an expected slot both resp_valids must be low.
    always @(posedge CLK) begin
        logic ea, eb;
        logic [7:0] ed;
        exp_t e;
        #1;
        ea = 1'b0; eb = 1'b0; ed = 8'h00;
        if (sb0.size() > 0 && sb0[0].due == cyc) begin
            e  = sb0.pop_front();
            ea = (e.port == 1'b0);
            eb = (e.port == 1'b1);
            ed = e.data;
        end
        vectors++;
        if ({a_rv[0], b_rv[0]} !== {ea, eb}) begin
            miscompares++;
            $display("[TB] FAIL p0_resp_valid cyc %0d: got a/b=%b%b expected %b%b", cyc, a_rv[0], b_rv[0], ea, eb);
        end
        if (ea || eb) begin
            vectors++;
            if ((ea ? a_rd[0] : b_rd[0]) !== ed) begin
                miscompares++;
                $display("[TB] FAIL p0_resp_data cyc %0d: got %0h expected %0h", cyc, ea ? a_rd[0] : b_rd[0], ed);
            end
        end
    end

    always @(posedge CLK) begin
        logic ea, eb;
        logic [7:0] ed;
        exp_t e;
        #1;
        ea = 1'b0; eb = 1'b0; ed = 8'h00;
        if (sb1.size() > 0 && sb1[0].due == cyc) begin
            e  = sb1.pop_front();
            ea = (e.port == 1'b0);
            eb = (e.port == 1'b1);
            ed = e.data;
        end
        vectors++;
        if ({a_rv[1], b_rv[1]} !== {ea, eb}) begin
            miscompares++;
            $display("[TB] FAIL p1_resp_valid cyc %0d: got a/b=%b%b expected %b%b", cyc, a_rv[1], b_rv[1], ea, eb);
        end
        if (ea || eb) begin
            vectors++;
            if ((ea ? a_rd[1] : b_rd[1]) !== ed) begin
                miscompares++;
                $display("[TB] FAIL p1_resp_data cyc %0d: got %0h expected %0h", cyc, ea ? a_rd[1] : b_rd[1], ed);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Applies one cycle of requests and advances the reference model.
    task automatic drive(input logic av, input logic awe, input logic [3:0] aad, input logic [7:0] adt,
                         input logic bv, input logic bwe, input logic [3:0] bad, input logic [7:0] bdt);
        a_req_valid = av; a_req_we = awe; a_req_addr = aad; a_req_data = adt;
        b_req_valid = bv; b_req_we = bwe; b_req_addr = bad; b_req_data = bdt;
        #1;
        exp_ga = 1'b0; exp_gb = 1'b0;
        if (RST_N) begin
            if (av && bv) begin
                exp_ga = (ptr_m == 1'b0);
                exp_gb = (ptr_m == 1'b1);
            end else begin
                exp_ga = av;
                exp_gb = bv;
            end
        end
        exp_we = 1'b0; exp_addr = 4'h0; exp_di = 8'h00;
        if (exp_ga) begin
            exp_we = awe; exp_addr = aad; exp_di = adt; ptr_m = 1'b1;
        end else if (exp_gb) begin
            exp_we = bwe; exp_addr = bad; exp_di = bdt; ptr_m = 1'b0;
        end
        if (exp_ga || exp_gb) begin
            if (exp_we) begin
                shadow[exp_addr] = exp_di;
            end else begin
                sb0.push_back('{due: cyc + 1, port: exp_gb, data: shadow[exp_addr]});
                sb1.push_back('{due: cyc + 2, port: exp_gb, data: shadow[exp_addr]});
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 4'h5, 8'hEE, 1'b1, 1'b0, 4'h6, 8'hDD);
        vectors++;
        if ({a_ready, b_ready} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b expected 0000", {a_ready, b_ready});
        end
        vectors++;
        if ({bram_en, bram_we} !== 4'b0000 || bram_addr !== '0 || bram_di !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_bram: got en=%b we=%b addr=%h di=%h expected all 0", bram_en, bram_we, bram_addr, bram_di);
        end
        RST_N = 1'b1;
    endtask

    task automatic test_contention();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            drive(1'b1, 1'b1, 4'(i), 8'hA0 + 8'(i), 1'b1, 1'b1, 4'(8 + i), 8'hB0 + 8'(i));
            vectors++;
            if (a_ready !== {2{i % 2 == 0}} || b_ready !== {2{i % 2 == 1}}) begin
                miscompares++;
                $display("[TB] FAIL contention_grant cyc %0d: got a=%b b=%b expected a=%b", i, a_ready, b_ready, i % 2 == 0);
            end
            vectors++;
            if (bram_en !== 2'b11 || bram_we !== 2'b11 || bram_addr !== {2{exp_addr}} || bram_di !== {2{exp_di}}) begin
                miscompares++;
                $display("[TB] FAIL contention_bram cyc %0d: got addr=%h di=%h expected %h %h", i, bram_addr, bram_di, exp_addr, exp_di);
            end
        end
        tick();
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b1, 4'h3, 8'h5A, 1'b0, 1'b0, 4'h0, 8'h00);
        vectors++;
        if (a_ready !== 2'b11 || b_ready !== 2'b00 || bram_we !== 2'b11 || bram_addr !== {2{4'h3}} || bram_di !== {2{8'h5A}}) begin
            miscompares++;
            $display("[TB] FAIL write_a: got rdy=%b we=%b addr=%h di=%h expected 11 11 3 5a", a_ready, bram_we, bram_addr, bram_di);
        end
        tick();
        drive(1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        vectors++;
        if (a_ready !== 2'b11 || bram_en !== 2'b11 || bram_we !== 2'b00 || bram_addr !== {2{4'h3}}) begin
            miscompares++;
            $display("[TB] FAIL read_a: got rdy=%b en=%b we=%b addr=%h expected 11 11 00 3", a_ready, bram_en, bram_we, bram_addr);
        end
        tick();
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        vectors++;
        if (bram_en !== 2'b00 || bram_we !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL idle_bram: got en=%b we=%b expected 00 00", bram_en, bram_we);
        end
        repeat (3) tick();
    endtask

    task automatic test_pipelined_read();
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 4'h7, 8'h11);
        tick();
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h7, 8'h00);
        vectors++;
        if (b_ready !== 2'b11 || a_ready !== 2'b00 || bram_addr !== {2{4'h7}}) begin
            miscompares++;
            $display("[TB] FAIL read_b: got b=%b a=%b addr=%h expected 11 00 7", b_ready, a_ready, bram_addr);
        end
        tick();
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] alist [4];
        logic [3:0] blist [4];
        alist = '{4'h0, 4'h2, 4'h3, 4'h7};
        blist = '{4'h9, 4'hB, 4'h7, 4'h3};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, alist[i % 4], 8'h00, 1'b1, 1'b0, blist[i % 4], 8'h00);
            vectors++;
            if (a_ready !== {2{exp_ga}} || b_ready !== {2{exp_gb}} || a_ready === b_ready || bram_addr !== {2{exp_addr}}) begin
                miscompares++;
                $display("[TB] FAIL b2b_grant %0d: got a=%b b=%b addr=%h expected a=%b b=%b addr=%h", i, a_ready, b_ready, bram_addr, exp_ga, exp_gb, exp_addr);
            end
            tick();
        end
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        repeat (3) tick();
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        tick();
        #1;
        RST_N = 1'b0;
        sb0.delete();
        sb1.delete();
        ptr_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 4'h2, 8'h00, 1'b1, 1'b0, 4'h9, 8'h00);
            vectors++;
            if ({a_ready, b_ready} !== 4'b0000 || bram_en !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL midflight_rst %0d: got rdy=%b en=%b expected 0000 00", i, {a_ready, b_ready}, bram_en);
            end
            tick();
        end
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        RST_N = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        RST_N = 1'b0;
        ptr_m = 1'b0;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 4'h0; a_req_data = 8'h00;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 4'h0; b_req_data = 8'h00;
        for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
        repeat (2) tick();
        test_reset();
        test_contention();
        test_write_read();
        test_pipelined_read();
        test_back_to_back();
        test_reset_midflight();
        vectors++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL pending_resp: got %0d/%0d outstanding expected 0/0", sb0.size(), sb1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no completion expected finish before 100000");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/bram1_arbiter.md
BRAM1_ARBITER -- requirements
Module: bram1_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 1, BRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 1, BRAM data width.
REQ-003 SHALL have parameter PIPELINED, default 0, matching the attached BRAM (0: 1-cycle read, 1: 2-cycle read).
REQ-004 SHALL have one clock and an asynchronous active-low reset: CLK input 1 (sole clock), RST_N input 1 (async, active-low).
REQ-005 SHALL have per requester port p in {a,b}:
- p_req_valid input 1, request present
- p_req_ready output 1, request accepted this cycle
- p_req_we input 1, 1=write, 0=read
- p_req_addr input ADDR_WIDTH
- p_req_data input DATA_WIDTH, write data
- p_resp_valid output 1, read data valid
- p_resp_data output DATA_WIDTH
REQ-006 SHALL have BRAM-side ports:
- bram_en output 1
- bram_we output 1
- bram_addr output ADDR_WIDTH
- bram_di output DATA_WIDTH
- bram_do input DATA_WIDTH

Function
REQ-007 SHALL grant at most one port per cycle; handshake = p_req_valid & p_req_ready.
REQ-008 SHALL compute p_req_ready combinationally from both valids and the priority pointer; ready SHALL NOT depend on the other port's ready.
REQ-009 SHALL give a lone valid requester the grant in the same cycle.
REQ-010 SHALL resolve simultaneous valids by round-robin: grant the pointer's port, then set the pointer to the other port; a lone grant also sets the pointer to the non-granted port.
REQ-011 SHALL drive the BRAM in the handshake cycle:
- bram_en=1
- bram_we=p_req_we
- bram_addr=p_req_addr
- bram_di=p_req_data
REQ-012 SHALL hold bram_en=0 and bram_we=0 in cycles without a handshake.
REQ-013 SHALL keep a tag shift pipeline of depth 1+PIPELINED per cycle {valid, port, is_read}, loaded on every cycle (valid=0 when no handshake).
REQ-014 SHALL assert p_resp_valid exactly 1+PIPELINED cycles after a read handshake on port p, for one cycle, with p_resp_data=bram_do.
REQ-015 SHALL produce no response for writes; the BRAM write-through data SHALL be discarded.
REQ-016 SHALL drive both p_resp_data from bram_do unconditionally; only p_resp_valid qualifies the data.
REQ-017 SHALL sustain one access per cycle, e.g. back-to-back reads alternating a,b with responses in issue order.
REQ-018 Responses SHALL NOT be backpressured; requesters SHALL accept p_resp_valid when it is presented.
REQ-019 SHALL let a port that drops p_req_valid without a handshake withdraw the request with no side effect.

Reset
REQ-020 While RST_N=0, SHALL drive:
- p_req_ready=0
- p_resp_valid=0
- bram_en=0
- bram_we=0
- bram_addr=0
- bram_di=0
- priority pointer=a
- all tag valids=0
REQ-021 SHALL discard reads in flight when reset asserts mid-operation; they SHALL produce no response after reset is released.
REQ-022 SHALL allow the first handshake in the first CLK edge after RST_N deasserts.

Structure
REQ-023 Shared package bram1_arbiter_pkg SHALL hold the port-id type (PORT_A=0, PORT_B=1) and the tag record type {valid, port, is_read}.
REQ-024 Round-robin grant logic SHALL be one sub-module, bram1_arbiter_rr (inputs: two valids; outputs: two grants; holds the pointer).
REQ-025 bram1_arbiter SHALL connect directly to the team's single-port BRAM with identical ADDR_WIDTH/DATA_WIDTH/PIPELINED.

Verification
REQ-026 Lone write then read, PIPELINED=0: a writes 0x5A to addr 3 in cycle 0, a reads addr 3 in cycle 1 -> a_resp_valid in cycle 2 with 0x5A; no response in cycle 1.
REQ-027 Contention: a and b both continuously valid for 4 cycles from reset -> grants a,b,a,b; pointer alternates.
REQ-028 PIPELINED=1: b reads addr 7 (holding 0x11) in cycle 10 -> b_resp_valid only in cycle 12 with 0x11; a_resp_valid stays 0.
REQ-029 Back-to-back alternating reads, PIPELINED=1: 8 reads -> 8 responses, each on the correct port, in issue order, one per cycle.
REQ-030 Reset mid-flight: read issued, RST_N pulled low the next cycle -> no resp_valid during or after reset; ready=0 and bram_en=0 while reset is low.
